// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the data-memory arbiter and the memory port.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              cpu_req;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_valid;

  logic              dma_req;
  logic              dma_rw;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_lock;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_valid;

  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side: requests and memory read data in, grants and memory strobes out.
  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_valid,
    input  dma_req, dma_rw, dma_addr, dma_wdata, dma_lock,
    output dma_gnt, dma_rdata, dma_valid,
    output mem_en, mem_rw, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester/memory side, mirror of the arbiter view.
  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_valid,
    output dma_req, dma_rw, dma_addr, dma_wdata, dma_lock,
    input  dma_gnt, dma_rdata, dma_valid,
    input  mem_en, mem_rw, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master (CPU, DMA) arbiter for the single-port data memory: round-robin ties,
// locked DMA bursts, and a bounded CPU wait that forces the CPU a slot.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACC_CPU, ACC_DMA} state_e;

  state_e            state_q, state_d;
  logic              last_dma_q, last_dma_d;
  logic              lock_q, lock_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dma_gnt_q, dma_gnt_d;
  logic              cpu_valid_q, cpu_valid_d;
  logic              dma_valid_q, dma_valid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_win, dma_win;

  // Winner selection in IDLE; a locked DMA keeps the slot until the CPU has waited MAX_WAIT.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (state_q == IDLE) begin
      if (bus.cpu_req && bus.dma_req) begin
        if (lock_q && (wait_q < WAIT_W'(MAX_WAIT))) dma_win = 1'b1;
        else if (last_dma_q)                         cpu_win = 1'b1;
        else                                         dma_win = 1'b1;
      end else begin
        cpu_win = bus.cpu_req;
        dma_win = bus.dma_req;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_dma_d  = last_dma_q;
    lock_d      = lock_q;
    wait_d      = wait_q;
    mem_en_d    = 1'b0;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_gnt_d   = 1'b0;
    dma_gnt_d   = 1'b0;
    cpu_valid_d = 1'b0;
    dma_valid_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    if (state_q == ACC_CPU) begin
      wait_d = '0;
    end else if (bus.cpu_req && !cpu_gnt_q && (wait_q < WAIT_W'(MAX_WAIT))) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    case (state_q)
      IDLE: begin
        // Lock survives only a DMA win with dma_lock; any CPU slot or DMA idle drops it.
        lock_d = dma_win ? bus.dma_lock : 1'b0;
        if (cpu_win) begin
          state_d     = ACC_CPU;
          mem_en_d    = 1'b1;
          mem_rw_d    = bus.cpu_rw;
          mem_addr_d  = bus.cpu_addr;
          mem_wdata_d = bus.cpu_wdata;
          cpu_gnt_d   = 1'b1;
        end else if (dma_win) begin
          state_d     = ACC_DMA;
          mem_en_d    = 1'b1;
          mem_rw_d    = bus.dma_rw;
          mem_addr_d  = bus.dma_addr;
          mem_wdata_d = bus.dma_wdata;
          dma_gnt_d   = 1'b1;
        end
      end
      ACC_CPU: begin
        state_d    = IDLE;
        last_dma_d = 1'b0;
        if (!mem_rw_q) begin
          cpu_rdata_d = bus.mem_rdata;
          cpu_valid_d = 1'b1;
        end
      end
      ACC_DMA: begin
        state_d    = IDLE;
        last_dma_d = 1'b1;
        if (!mem_rw_q) begin
          dma_rdata_d = bus.mem_rdata;
          dma_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Async reset also kills an in-flight access: mem_en and gnt drop immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_dma_q  <= 1'b1;
      lock_q      <= 1'b0;
      wait_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      cpu_valid_q <= 1'b0;
      dma_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      lock_q      <= lock_d;
      wait_q      <= wait_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_gnt_q   <= cpu_gnt_d;
      dma_gnt_q   <= dma_gnt_d;
      cpu_valid_q <= cpu_valid_d;
      dma_valid_q <= dma_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt_q;
  assign bus.dma_gnt   = dma_gnt_q;
  assign bus.cpu_valid = cpu_valid_q;
  assign bus.dma_valid = dma_valid_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule
